ide_pio_ctrl: RTL

- Parametrised IDE/ATA PIO interface controller for the 68000 expansion bus.
- Decodes up to four IDE channels in the board's IDE window.
- Sequences setup, strobe and recovery using per-direction cycle counters, honours device IORDY with a timeout, and generates DTACK_n for register cycles.
- Keeps the boot-ROM overlay behaviour: ROM occupies the whole window until the first write enables the IDE registers.

---
 rtl/ide_pio_if.sv | 32 +++
 rtl/ide_pio_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ide_pio_if.sv
// IDE PIO bus bundle: 68000-side bus inputs plus the IDE strobes, chip selects and status
// returned by the controller.
//   slave  : controller view (bus/IDE inputs in, strobes/acks/status out)
//   master : CPU/board view (drives bus/IDE inputs, observes outputs)
interface ide_pio_if #(
  parameter int unsigned NUM_CH = 2
) ();
  logic [23:1]           ADDR;
  logic                  UDS_n;
  logic                  LDS_n;
  logic                  RW;
  logic                  AS_n;
  logic                  ide_access;
  logic                  IORDY;
  logic                  IOR_n;
  logic                  IOW_n;
  logic [2*NUM_CH-1:0]   CS_n;
  logic                  DTACK_n;
  logic                  IDE_ROMEN;
  logic                  ide_enabled;
  logic                  timeout;

  modport slave (
    input  ADDR, UDS_n, LDS_n, RW, AS_n, ide_access, IORDY,
    output IOR_n, IOW_n, CS_n, DTACK_n, IDE_ROMEN, ide_enabled, timeout
  );

  modport master (
    output ADDR, UDS_n, LDS_n, RW, AS_n, ide_access, IORDY,
    input  IOR_n, IOW_n, CS_n, DTACK_n, IDE_ROMEN, ide_enabled, timeout
  );
endinterface

// File: rtl/ide_pio_ctrl.sv
// IDE/ATA PIO controller for the 68000 expansion bus.
// Decodes up to four IDE channels inside the board's IDE window, sequences setup, strobe and
// recovery with per-direction cycle counts, waits on IORDY with a timeout and generates DTACK_n
// for register cycles. The boot ROM covers the whole window until the first write to it.
// Ports:
//   CLK, RESET_n : bus clock, asynchronous active-low reset
//   bus          : ide_pio_if.slave (CPU address/strobes, IORDY in; IOR_n/IOW_n, CS_n,
//                  DTACK_n, IDE_ROMEN, ide_enabled, sticky timeout out)
module ide_pio_ctrl #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned READ_CYC  = 3,
  parameter int unsigned WRITE_CYC = 2,
  parameter int unsigned TO_CYC    = 255
) (
  input logic       CLK,
  input logic       RESET_n,
  ide_pio_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StWaitRdy, StDone} state_e;

  localparam logic [3:0] SetupLoad = 4'(SETUP_CYC - 1);
  localparam logic [3:0] ReadLoad  = 4'(READ_CYC - 1);
  localparam logic [3:0] WriteLoad = 4'(WRITE_CYC - 1);
  localparam logic [7:0] ToLast    = 8'(TO_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        rw_l_q, rw_l_d;
  logic        ide_enabled_q, ide_enabled_d;
  logic        timeout_q, timeout_d;

  logic [1:0]          ch;
  logic [1:0]          rsel;
  logic                reg_hit;
  logic                start;
  logic [2*NUM_CH-1:0] cs_n;
  logic                unused_addr;

  assign unused_addr = ^{bus.ADDR[23:17], bus.ADDR[11:1]};

  function automatic logic [3:0] strobe_load(input logic rd);
    return rd ? ReadLoad : WriteLoad;
  endfunction

  // Address decode
  assign ch      = bus.ADDR[15:14];
  assign rsel    = bus.ADDR[13:12];
  assign reg_hit = ide_enabled_q && bus.ide_access && !bus.ADDR[16] &&
                   ({30'd0, ch} < NUM_CH) && (rsel == 2'b01 || rsel == 2'b10);
  assign start   = !bus.AS_n && (!bus.UDS_n || !bus.LDS_n) && reg_hit;

  always_comb begin
    cs_n = '1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (reg_hit && ch == 2'(i)) begin
        cs_n[2*i]   = (rsel != 2'b01);
        cs_n[2*i+1] = (rsel != 2'b10);
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tcnt_d        = tcnt_q;
    rw_l_d        = rw_l_q;
    timeout_d     = timeout_q;
    ide_enabled_d = ide_enabled_q |
                    (bus.ide_access && !bus.RW && !bus.UDS_n && !bus.AS_n);

    if (bus.AS_n) begin
      // Abort or normal end of bus cycle
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            rw_l_d = bus.RW;
            if (SETUP_CYC == 0) begin
              state_d = StStrobe;
              cnt_d   = strobe_load(bus.RW);
            end else begin
              state_d = StSetup;
              cnt_d   = SetupLoad;
            end
          end
        end
        StSetup: begin
          if (cnt_q == 4'd0) begin
            state_d = StStrobe;
            cnt_d   = strobe_load(rw_l_q);
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            if (bus.IORDY) begin
              state_d = StDone;
            end else begin
              state_d = StWaitRdy;
              tcnt_d  = 8'd0;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StWaitRdy: begin
          if (bus.IORDY) begin
            state_d = StDone;
          end else if (tcnt_q == ToLast) begin
            state_d   = StDone;
            timeout_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      tcnt_q        <= 8'd0;
      rw_l_q        <= 1'b0;
      ide_enabled_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      rw_l_q        <= rw_l_d;
      ide_enabled_q <= ide_enabled_d;
      timeout_q     <= timeout_d;
    end
  end

  // Outputs: AS_n gates strobes and DTACK directly so they drop the instant AS_n rises.
  // Read strobe stays on through DONE to keep data valid; write strobe releases for hold.
  assign bus.IOR_n = !(!bus.AS_n && rw_l_q &&
                       (state_q == StStrobe || state_q == StWaitRdy || state_q == StDone));
  assign bus.IOW_n = !(!bus.AS_n && !rw_l_q &&
                       (state_q == StStrobe || state_q == StWaitRdy));
  assign bus.DTACK_n     = !(!bus.AS_n && state_q == StDone);
  assign bus.CS_n        = cs_n;
  assign bus.IDE_ROMEN   = !(!bus.AS_n && bus.ide_access &&
                             (!ide_enabled_q || bus.ADDR[16] || rsel == 2'b00 || rsel == 2'b11));
  assign bus.ide_enabled = ide_enabled_q;
  assign bus.timeout     = timeout_q;

endmodule
